// File: rtl/vga_timing_core_if.sv
// vga_timing_core_if
//   Bundles the run-control inputs and the timing outputs of vga_timing_core.
//   master : the timing core (drives the timing outputs, receives en/speed)
//   slave  : the consumer (drives en/speed, receives the timing outputs)
//
//   en          run enable for the timing path
//   speed       game-tick rate select (period = TICK_DIV >> speed)
//   pix_ce      pixel clock-enable pulse
//   hcount      current pixel column
//   vcount      current line
//   hs, vs      horizontal / vertical sync
//   de          active-video flag
//   line_start  one-cycle pulse when column 0 is first presented
//   frame_start one-cycle pulse when (0,0) is first presented
//   game_tick   one-cycle game-tick pulse
//   tick_toggle square wave, inverts on every game_tick
interface vga_timing_core_if #(
  parameter int CW = 10
);
  logic          en;
  logic [1:0]    speed;
  logic          pix_ce;
  logic [CW-1:0] hcount;
  logic [CW-1:0] vcount;
  logic          hs;
  logic          vs;
  logic          de;
  logic          line_start;
  logic          frame_start;
  logic          game_tick;
  logic          tick_toggle;

  modport master (
    input  en, speed,
    output pix_ce, hcount, vcount, hs, vs, de,
           line_start, frame_start, game_tick, tick_toggle
  );

  modport slave (
    output en, speed,
    input  pix_ce, hcount, vcount, hs, vs, de,
           line_start, frame_start, game_tick, tick_toggle
  );
endinterface

// File: rtl/vga_timing_core.sv
// vga_timing_core
//   Parametrised VGA timing and game-tick generator running entirely on
//   clk_in. A pixel clock-enable replaces any derived pixel clock; position,
//   sync, data-enable and start pulses advance only on enabled cycles. A
//   separate counter produces a game tick whose period is selectable at run
//   time.
//
// Ports
//   clk_in  system clock
//   reset   asynchronous, active-high
//   bus     vga_timing_core_if.master (en, speed in; timing outputs out)
//
// All outputs are registered.
module vga_timing_core #(
  parameter int PIX_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 10,
  parameter int TICK_DIV = 300000,
  parameter int TICK_W   = 20
) (
  input  logic               clk_in,
  input  logic               reset,
  vga_timing_core_if.master  bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  // Decode compares use one extra bit so a sync end equal to 2^CW still works.
  localparam int XW      = CW + 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT_X  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HS_BEG_X = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_END_X = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [XW-1:0] V_ACT_X  = XW'(V_ACTIVE);
  localparam logic [XW-1:0] VS_BEG_X = XW'(V_ACTIVE + V_FP);
  localparam logic [XW-1:0] VS_END_X = XW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [TICK_W-1:0] TICK_BASE = TICK_W'(TICK_DIV);

  // Timing path state
  logic [DW-1:0] div_reg, div_next;
  logic          pix_ce_reg;
  logic [CW-1:0] hcount_reg, vcount_reg;
  logic [CW-1:0] h_next, v_next;
  logic [XW-1:0] h_ext, v_ext;
  logic          hs_reg, vs_reg, de_reg;
  logic          hs_next, vs_next, de_next;
  logic          line_start_reg, frame_start_reg;

  // Game tick state
  logic [TICK_W-1:0] tick_cnt_reg;
  logic [TICK_W-1:0] tick_period_next, tick_last_next;
  logic              game_tick_reg, tick_toggle_reg;

  // Next divider value, next raster position and its decode. Sync and
  // data-enable are decoded from the position being loaded, so they line up
  // with hcount/vcount with no extra skew.
  always_comb begin
    div_next = (div_reg == DIV_LAST) ? '0 : div_reg + 1'b1;
    h_next   = hcount_reg + 1'b1;
    v_next   = vcount_reg;
    if (hcount_reg == H_LAST) begin
      h_next = '0;
      v_next = (vcount_reg == V_LAST) ? '0 : vcount_reg + 1'b1;
    end
    h_ext   = {1'b0, h_next};
    v_ext   = {1'b0, v_next};
    de_next = (h_ext < H_ACT_X) && (v_ext < V_ACT_X);
    hs_next = ((h_ext >= HS_BEG_X) && (h_ext < HS_END_X)) ? HS_POL : ~HS_POL;
    vs_next = ((v_ext >= VS_BEG_X) && (v_ext < VS_END_X)) ? VS_POL : ~VS_POL;
  end

  // Timing path. Reset parks the raster on the last pixel of the last line so
  // the first advance lands on (0,0); dropping en returns to that same state.
  // pix_ce is raised in the cycle the divider sits at its last count, and the
  // raster advances on the edge that ends that cycle.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      div_reg         <= '0;
      pix_ce_reg      <= 1'b0;
      hcount_reg      <= H_LAST;
      vcount_reg      <= V_LAST;
      hs_reg          <= ~HS_POL;
      vs_reg          <= ~VS_POL;
      de_reg          <= 1'b0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end else if (!bus.en) begin
      div_reg         <= '0;
      pix_ce_reg      <= 1'b0;
      hcount_reg      <= H_LAST;
      vcount_reg      <= V_LAST;
      hs_reg          <= ~HS_POL;
      vs_reg          <= ~VS_POL;
      de_reg          <= 1'b0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      div_reg    <= div_next;
      pix_ce_reg <= (div_next == DIV_LAST);
      if (pix_ce_reg) begin
        hcount_reg      <= h_next;
        vcount_reg      <= v_next;
        hs_reg          <= hs_next;
        vs_reg          <= vs_next;
        de_reg          <= de_next;
        line_start_reg  <= (h_next == '0);
        frame_start_reg <= (h_next == '0) && (v_next == '0);
      end else begin
        line_start_reg  <= 1'b0;
        frame_start_reg <= 1'b0;
      end
    end
  end

  // Tick period for the current speed, never below one cycle.
  always_comb begin
    tick_period_next = TICK_BASE >> bus.speed;
    if (tick_period_next == '0) begin
      tick_period_next = TICK_W'(1);
    end
    tick_last_next = tick_period_next - 1'b1;
  end

  // Game tick. The >= compare makes a speed-up that leaves the counter past
  // the new terminal count tick on the next edge instead of running on to
  // wrap-around.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      tick_cnt_reg    <= '0;
      game_tick_reg   <= 1'b0;
      tick_toggle_reg <= 1'b0;
    end else if (tick_cnt_reg >= tick_last_next) begin
      tick_cnt_reg    <= '0;
      game_tick_reg   <= 1'b1;
      tick_toggle_reg <= ~tick_toggle_reg;
    end else begin
      tick_cnt_reg    <= tick_cnt_reg + 1'b1;
      game_tick_reg   <= 1'b0;
    end
  end

  assign bus.pix_ce      = pix_ce_reg;
  assign bus.hcount      = hcount_reg;
  assign bus.vcount      = vcount_reg;
  assign bus.hs          = hs_reg;
  assign bus.vs          = vs_reg;
  assign bus.de          = de_reg;
  assign bus.line_start  = line_start_reg;
  assign bus.frame_start = frame_start_reg;
  assign bus.game_tick   = game_tick_reg;
  assign bus.tick_toggle = tick_toggle_reg;

endmodule

// File: tb/tb_vga_timing_core.sv
// tb_vga_timing_core
//   dut_a: small raster (15x9, PIX_DIV=3, active-high hs, active-low vs,
//          TICK_DIV=50) checked every cycle against an arithmetic reference
//          model, plus a table of hand-computed vectors and tick sequences.
//   dut_b: default raster with PIX_DIV=1 and active-high hs, checked for
//          constant pix_ce and the hs width per line.
module tb_vga_timing_core;

  localparam int PD  = 3;
  localparam int HA  = 8, HF = 2, HSY = 3, HB = 2;
  localparam int VA  = 4, VF = 1, VSY = 2, VB = 2;
  localparam int HT  = HA + HF + HSY + HB;
  localparam int VT  = VA + VF + VSY + VB;
  localparam int TOT = HT * VT;
  localparam bit HP  = 1'b1;
  localparam bit VP  = 1'b0;
  localparam int TD  = 50;

  logic clk_in = 1'b0;
  logic reset  = 1'b0;
  always #5 clk_in = ~clk_in;

  vga_timing_core_if #(.CW(5))  bus_a ();
  vga_timing_core_if #(.CW(10)) bus_b ();

  vga_timing_core #(
    .PIX_DIV(PD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(HP), .VS_POL(VP), .CW(5), .TICK_DIV(TD), .TICK_W(6)
  ) dut_a (
    .clk_in(clk_in),
    .reset(reset),
    .bus(bus_a)
  );

  vga_timing_core #(
    .PIX_DIV(1), .HS_POL(1'b1)
  ) dut_b (
    .clk_in(clk_in),
    .reset(reset),
    .bus(bus_b)
  );

  typedef struct packed {
    logic       pix_ce;
    logic [4:0] h;
    logic [4:0] v;
    logic       hs;
    logic       vs;
    logic       de;
    logic       ls;
    logic       fs;
    logic       tick;
    logic       tog;
  } obs_t;

  typedef struct {
    int en;
    int cyc;
    int pce;
    int h;
    int v;
    int hs;
    int vs;
    int de;
    int ls;
    int fs;
  } vec_t;

  int total;
  int bad;

  // Reference model state: edges run with en high since the last restart,
  // and edges elapsed since the last game tick.
  int  m_k;
  int  m_since;
  bit  m_tick;
  bit  m_tog;

  vec_t tbl [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int period(input int s);
    int p;
    p = TD >> s;
    return (p < 1) ? 1 : p;
  endfunction

  // Raster position is the number of pixel advances so far, counted from the
  // parked last position; advances occur on every PD-th enabled edge.
  function automatic obs_t model_out();
    obs_t o;
    int n, idx, h, v;
    n   = m_k / PD;
    idx = (n + TOT - 1) % TOT;
    h   = idx % HT;
    v   = idx / HT;
    o.pix_ce = (m_k > 0) && (m_k % PD == PD - 1);
    o.h      = 5'(h);
    o.v      = 5'(v);
    o.hs     = (h >= HA + HF && h < HA + HF + HSY) ? HP : ~HP;
    o.vs     = (v >= VA + VF && v < VA + VF + VSY) ? VP : ~VP;
    o.de     = (h < HA) && (v < VA);
    o.ls     = (m_k >= PD) && (m_k % PD == 0) && (h == 0);
    o.fs     = o.ls && (v == 0);
    o.tick   = m_tick;
    o.tog    = m_tog;
    return o;
  endfunction

  function automatic obs_t dut_out();
    obs_t o;
    o.pix_ce = bus_a.pix_ce;
    o.h      = bus_a.hcount;
    o.v      = bus_a.vcount;
    o.hs     = bus_a.hs;
    o.vs     = bus_a.vs;
    o.de     = bus_a.de;
    o.ls     = bus_a.line_start;
    o.fs     = bus_a.frame_start;
    o.tick   = bus_a.game_tick;
    o.tog    = bus_a.tick_toggle;
    return o;
  endfunction

  function automatic obs_t reset_obs();
    obs_t o;
    o    = '0;
    o.h  = 5'd14;
    o.v  = 5'd8;
    o.hs = 1'b0;
    o.vs = 1'b1;
    return o;
  endfunction

  // One clock: advance the model with the inputs the DUT sees, then compare.
  task automatic step();
    obs_t exp_o;
    obs_t act_o;
    @(posedge clk_in);
    if (!reset) begin
      if (bus_a.en) m_k++;
      else m_k = 0;
      m_since++;
      if (m_since >= period(int'(bus_a.speed))) begin
        m_since = 0;
        m_tick  = 1'b1;
        m_tog   = ~m_tog;
      end else begin
        m_tick  = 1'b0;
      end
    end
    #1;
    exp_o = model_out();
    act_o = dut_out();
    check("model", 32'(act_o), 32'(exp_o));
  endtask

  // Pulse reset between clock edges and check the outputs with no edge.
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    m_k = 0; m_since = 0; m_tick = 1'b0; m_tog = 1'b0;
    check(tag, 32'(dut_out()), 32'(reset_obs()));
    @(negedge clk_in);
    reset = 1'b0;
    $display("reset %s h=%0d v=%0d hs=%0d vs=%0d", tag, bus_a.hcount, bus_a.vcount, bus_a.hs, bus_a.vs);
  endtask

  task automatic wait_tick(input string tag, input int lim, input int exp_n);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!bus_a.game_tick && n < lim);
    check({tag, "_seen"}, 32'(bus_a.game_tick), 32'd1);
    check(tag, 32'(n), 32'(exp_n));
    $display("tick %s speed=%0d en=%0d cycles=%0d toggle=%0d", tag, bus_a.speed, bus_a.en, n, bus_a.tick_toggle);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish by 1000000");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, hs_cnt, pce_low, ls_cnt, last, rise_h, seg_bad, len;
    logic prev_hs;

    total = 0; bad = 0;
    m_k = 0; m_since = 0; m_tick = 1'b0; m_tog = 1'b0;

    //          en cyc pce  h  v hs vs de ls fs
    tbl[0]  = '{1,   3, 0,  0, 0, 0, 1, 1, 1, 1};
    tbl[1]  = '{1,   1, 0,  0, 0, 0, 1, 1, 0, 0};
    tbl[2]  = '{1,   1, 1,  0, 0, 0, 1, 1, 0, 0};
    tbl[3]  = '{1,   1, 0,  1, 0, 0, 1, 1, 0, 0};
    tbl[4]  = '{1,  27, 0, 10, 0, 1, 1, 0, 0, 0};
    tbl[5]  = '{1,   9, 0, 13, 0, 0, 1, 0, 0, 0};
    tbl[6]  = '{1,   3, 0, 14, 0, 0, 1, 0, 0, 0};
    tbl[7]  = '{1,   3, 0,  0, 1, 0, 1, 1, 1, 0};
    tbl[8]  = '{1, 180, 0,  0, 5, 0, 0, 0, 1, 0};
    tbl[9]  = '{0,   1, 0, 14, 8, 0, 1, 0, 0, 0};
    tbl[10] = '{0,   5, 0, 14, 8, 0, 1, 0, 0, 0};
    tbl[11] = '{1,   3, 0,  0, 0, 0, 1, 1, 1, 1};
    tbl[12] = '{1, 270, 0,  0, 6, 0, 0, 0, 1, 0};
    tbl[13] = '{1,  45, 0,  0, 7, 0, 1, 0, 1, 0};
    tbl[14] = '{1,  90, 0,  0, 0, 0, 1, 1, 1, 1};

    bus_a.en = 1'b1; bus_a.speed = 2'd0;
    bus_b.en = 1'b1; bus_b.speed = 2'd0;

    // Power-up reset: values must appear without any clock edge.
    #1 reset = 1'b1;
    #1;
    check("reset_noclk", 32'(dut_out()), 32'(reset_obs()));
    repeat (3) @(posedge clk_in);
    #1;
    check("reset_hold", 32'(dut_out()), 32'(reset_obs()));
    @(negedge clk_in);
    reset = 1'b0;

    // Table-driven vectors from reset release.
    for (int i = 0; i < 15; i++) begin
      bus_a.en = tbl[i].en[0];
      repeat (tbl[i].cyc) step();
      check("vec_pce", 32'(bus_a.pix_ce), 32'(tbl[i].pce));
      check("vec_h",   32'(bus_a.hcount), 32'(tbl[i].h));
      check("vec_v",   32'(bus_a.vcount), 32'(tbl[i].v));
      check("vec_hs",  32'(bus_a.hs), 32'(tbl[i].hs));
      check("vec_vs",  32'(bus_a.vs), 32'(tbl[i].vs));
      check("vec_de",  32'(bus_a.de), 32'(tbl[i].de));
      check("vec_ls",  32'(bus_a.line_start), 32'(tbl[i].ls));
      check("vec_fs",  32'(bus_a.frame_start), 32'(tbl[i].fs));
      $display("vec %0d en=%0d cyc=%0d h=%0d v=%0d hs=%0d vs=%0d de=%0d ls=%0d fs=%0d",
               i, tbl[i].en, tbl[i].cyc, bus_a.hcount, bus_a.vcount, bus_a.hs,
               bus_a.vs, bus_a.de, bus_a.line_start, bus_a.frame_start);
    end

    // PIX_DIV=1 instance: constant pix_ce, 96 hs-high cycles per 800-cycle line.
    n = 0;
    do begin
      step();
      n++;
    end while (!bus_b.line_start && n < 2000);
    check("b_line_seen", 32'(bus_b.line_start), 32'd1);
    hs_cnt = 0; pce_low = 0; ls_cnt = 0; last = 0; rise_h = -1;
    prev_hs = bus_b.hs;
    for (int c = 1; c <= 2400; c++) begin
      step();
      if (bus_b.hs) hs_cnt++;
      if (!bus_b.pix_ce) pce_low++;
      if (bus_b.hs && !prev_hs && rise_h < 0) rise_h = int'(bus_b.hcount);
      prev_hs = bus_b.hs;
      if (bus_b.line_start) begin
        ls_cnt++;
        check("b_line_period", 32'(c - last), 32'd800);
        last = c;
      end
    end
    check("b_hs_high", 32'(hs_cnt), 32'd288);
    check("b_pce_low", 32'(pce_low), 32'd0);
    check("b_lines", 32'(ls_cnt), 32'd3);
    check("b_hs_rise_h", 32'(rise_h), 32'd656);
    $display("pixdiv1 hs_high=%0d pce_low=%0d lines=%0d hs_rise_h=%0d", hs_cnt, pce_low, ls_cnt, rise_h);

    // Game tick periods, en independence and a speed-up past the new limit.
    async_reset("tick_reset");
    bus_a.speed = 2'd0;
    wait_tick("tick_p0_first", 200, 50);
    check("toggle_after_1", 32'(bus_a.tick_toggle), 32'd1);
    wait_tick("tick_p0", 200, 50);
    check("toggle_after_2", 32'(bus_a.tick_toggle), 32'd0);
    bus_a.en = 1'b0;
    bus_a.speed = 2'd2;
    wait_tick("tick_p2_en0", 200, 12);
    wait_tick("tick_p2_en0", 200, 12);
    check("en0_h_parked", 32'(bus_a.hcount), 32'd14);
    bus_a.en = 1'b1;
    bus_a.speed = 2'd0;
    wait_tick("tick_p0_again", 200, 50);
    repeat (40) step();
    bus_a.speed = 2'd1;
    wait_tick("tick_speedup", 200, 1);
    wait_tick("tick_p1", 200, 25);
    bus_a.speed = 2'd3;
    wait_tick("tick_p3", 200, 6);

    // Random segments of en/speed with occasional asynchronous resets.
    for (int s = 0; s < 80; s++) begin
      bus_a.en    = ($urandom_range(0, 4) != 0);
      bus_a.speed = 2'($urandom_range(0, 3));
      len = (s == 0) ? 500 : int'($urandom_range(1, 80));
      seg_bad = bad;
      repeat (len) step();
      if ($urandom_range(0, 9) == 0) async_reset("rand_reset");
      $display("seg %0d en=%0d speed=%0d len=%0d h=%0d v=%0d errors=%0d",
               s, bus_a.en, bus_a.speed, len, bus_a.hcount, bus_a.vcount, bad - seg_bad);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
